fsm2_rr_scheduler: RTL and testbench
====================================

// Module: fsm2_rr_scheduler
// PURPOSE
//  Shares one fsm2 two-state JK machine (inputs j/k, Moore output out) among
//  N requesters. Round-robin arbitration selects one requester at a time.
//  The scheduler drives one j/k command pulse into the FSM, waits for the
//  output to settle, then returns the resulting out value with an ack pulse.
//  Sits between the requesters and the single fsm2 instance; it is the only
//  driver of that instance's j and k inputs.
// PARAMETERS
//  N      4   number of requesters, 2..8
//  IDW    2   grant_id width, must satisfy 2**IDW >= N
// PORTS
//  clk       in   1      clock, all logic on the rising edge
//  areset    in   1      synchronous reset, active-high; shared with the fsm2 instance
//  req       in   N      per-requester request level, held until ack
//  cmd       in   2*N    per-requester command, cmd[2i+1:2i]
//                        00 = hold, 01 = set, 10 = clear, 11 = toggle
//  ack       out  N      one-hot, one-cycle completion pulse
//  result    out  1      FSM out value sampled after the command; valid while ack != 0
//  grant_id  out  IDW    index of the requester currently being served
//  busy      out  1      1 in any state other than IDLE
//  j         out  1      to fsm2 j
//  k         out  1      to fsm2 k
//  fsm_out   in   1      from fsm2 out
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state = IDLE, j = 0, k = 0, ack = 0, result = 0,
//    grant_id = 0, busy = 0, rr_ptr = N-1 (requester 0 has priority first).
//  - States and transitions:
//    - IDLE: if req != 0, select the first asserted requester scanning
//      rr_ptr+1, rr_ptr+2, ... with wrap mod N. Latch its index into
//      grant_id and rr_ptr, latch its cmd, go to ISSUE. Otherwise stay in IDLE.
//    - ISSUE (exactly 1 cycle): drive the latched command on j/k:
//      hold = j0 k0, set = j1 k0, clear = j0 k1, toggle = j1 k1. Go to SETTLE.
//    - SETTLE (1 cycle): j = k = 0. At the end of this cycle, register
//      result <= fsm_out. Go to ACK.
//    - ACK (1 cycle): ack[grant_id] = 1, all other ack bits 0. Go to IDLE.
//  - j and k are 0 in every state except ISSUE.
//  - Latency: req sampled at edge E0 -> ISSUE -> SETTLE -> ack high in the
//    cycle after E2. Back-to-back throughput is one command per 4 cycles.
//  - cmd is sampled only at the grant edge; later changes to cmd have no effect.
//  - If req drops while a command is in flight, the command still completes
//    and ack still pulses.
//  - A requester that keeps req high after its ack is re-eligible, but
//    rr_ptr has already advanced past it, so every other pending requester
//    is served before it again. With all N requests held, grants rotate
//    0,1,..,N-1,0.
//  - A request arriving during busy waits; it is arbitrated only in IDLE.
//  - areset in any state forces IDLE and reset values on the next edge. No
//    ack is produced for the aborted command. The fsm2 instance resets to
//    OFF (out = 0) on the same edge.
// TESTING
//  1. Reset, then req=0001, cmd0=01: j=1,k=0 for 1 cycle; ack=0001
//     3 cycles after the grant edge; result=1.
//  2. From out=1, req0 with cmd0=11 (toggle) -> result=0; a second toggle -> result=1.
//  3. req=1111 held, all cmd=11: grant_id sequence 0,1,2,3,0; each ack
//     4 cycles apart; result alternates 1,0,1,0,1.
//  4. req2 alone after serving 3 (rr_ptr=3): grant 2 immediately. Then
//     req=0101: grant 0 before 2, because rr_ptr is now 2.
//  5. Assert areset during SETTLE: next cycle busy=0, ack=0, j=k=0, out=0;
//     a held req is re-granted starting from requester 0.
//  6. cmd0 changed from 01 to 10 one cycle after the grant: j=1,k=0 is still
//     issued and result=1; cmd=00 leaves result equal to the prior out.

Source files
------------

// File: rtl/fsm2_rr_scheduler.sv
// Round-robin front end that time-shares one fsm2 JK machine among N requesters.
// Each grant walks through ISSUE -> SETTLE -> ACK and returns the settled FSM output.
module fsm2_rr_scheduler #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           areset,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] cmd,
  output logic [N-1:0]   ack,
  output logic           result,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           j,
  output logic           k,
  input  logic           fsm_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_ptr_nx;
  logic [IDW-1:0] grant_nx;
  logic [1:0]     cmd_q;
  logic [1:0]     cmd_nx;
  logic [N-1:0]   ack_nx;
  logic           result_nx;
  logic           busy_nx;
  logic           j_nx;
  logic           k_nx;

  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;

  // Scan from the farthest slot back to rr_ptr+1 so the last hit is the nearest one.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IDW'((int'(rr_ptr) + i) % N);
      if (req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    grant_nx  = grant_id;
    cmd_nx    = cmd_q;
    ack_nx    = '0;
    result_nx = result;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx  = pick;
          rr_ptr_nx = pick;
          cmd_nx    = cmd[{pick, 1'b0} +: 2];
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = SETTLE;
      end
      SETTLE: begin
        result_nx        = fsm_out;
        ack_nx[grant_id] = 1'b1;
        state_nx         = ACK;
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    busy_nx = (state_nx != IDLE);
    j_nx    = (state_nx == ISSUE) && cmd_nx[0];
    k_nx    = (state_nx == ISSUE) && cmd_nx[1];
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(N - 1);
      grant_id <= '0;
      cmd_q    <= 2'b00;
      ack      <= '0;
      result   <= 1'b0;
      busy     <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      grant_id <= grant_nx;
      cmd_q    <= cmd_nx;
      ack      <= ack_nx;
      result   <= result_nx;
      busy     <= busy_nx;
      j        <= j_nx;
      k        <= k_nx;
    end
  end

endmodule

// File: tb/tb_fsm2_rr_scheduler.sv
// Bench for fsm2_rr_scheduler: a JK stand-in for fsm2, a transaction-level reference
// model checked every cycle, a table of single-requester transactions and corner sequences.
module tb_fsm2_rr_scheduler;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           areset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] cmd = '0;
  logic [N-1:0]   ack;
  logic           result;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           j;
  logic           k;
  logic           fsm_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fsm2_rr_scheduler #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .areset   (areset),
    .req      (req),
    .cmd      (cmd),
    .ack      (ack),
    .result   (result),
    .grant_id (grant_id),
    .busy     (busy),
    .j        (j),
    .k        (k),
    .fsm_out  (fsm_out)
  );

  logic fsm_q = 1'b0;
  always @(posedge clk) begin
    if (areset) fsm_q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   fsm_q <= 1'b1;
        2'b01:   fsm_q <= 1'b0;
        2'b11:   fsm_q <= ~fsm_q;
        default: fsm_q <= fsm_q;
      endcase
    end
  end
  assign fsm_out = fsm_q;

  function automatic logic jkNext(input logic [1:0] c, input logic q);
    case (c)
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // Reference: m_age is the number of cycles since the grant, -1 when nothing is in flight.
  int         m_age = -1;
  int         m_ptr = N - 1;
  int         m_gid = 0;
  logic [1:0] m_cmd = 2'b00;
  logic       m_out = 1'b0;
  logic       m_res = 1'b0;

  always @(posedge clk) begin : ref_model
    int c;
    int pick;
    logic [2*N-1:0] sh;
    pick = -1;
    for (int s = 1; s <= N; s++) begin
      c = (m_ptr + s) % N;
      if (pick < 0 && ((req >> c) & N'(1)) != 0) pick = c;
    end
    sh = cmd >> (2 * ((pick < 0) ? 0 : pick));
    if (areset) begin
      m_age <= -1;
      m_ptr <= N - 1;
      m_gid <= 0;
      m_res <= 1'b0;
      m_out <= 1'b0;
    end else begin
      case (m_age)
        -1: if (pick >= 0) begin
          m_gid <= pick;
          m_ptr <= pick;
          m_cmd <= sh[1:0];
          m_age <= 0;
        end
        0: begin
          m_out <= jkNext(m_cmd, m_out);
          m_age <= 1;
        end
        1: begin
          m_res <= m_out;
          m_age <= 2;
        end
        default: m_age <= -1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_busy", 32'(busy), 32'(m_age >= 0));
      checkOutput("model_j", 32'(j), 32'((m_age == 0) && m_cmd[0]));
      checkOutput("model_k", 32'(k), 32'((m_age == 0) && m_cmd[1]));
      checkOutput("model_ack", 32'(ack), (m_age == 2) ? (32'd1 << m_gid) : 32'd0);
      checkOutput("model_grant", 32'(grant_id), 32'(m_gid));
      checkOutput("model_result", 32'(result), 32'(m_res));
      checkOutput("model_fsm_out", 32'(fsm_out), 32'(m_out));
    end
  end

  typedef struct {
    logic [N-1:0]   req;
    logic [2*N-1:0] cmd;
    int             gid;
    logic           res;
  } vec_t;

  vec_t tbl[10];

  task automatic waitAck(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == '0 && waited < limit);
    checkOutput("ack_arrived", 32'(ack != '0), 32'd1);
  endtask

  // Drive one request from an idle scheduler, wait for its ack and check it.
  task automatic applyStimulus(input vec_t v);
    int waited;
    @(negedge clk);
    req = v.req;
    cmd = v.cmd;
    waitAck(12, waited);
    checkOutput("latency", 32'(waited), 32'd3);
    checkOutput("tbl_grant", 32'(grant_id), 32'(v.gid));
    checkOutput("tbl_ack", 32'(ack), 32'd1 << v.gid);
    checkOutput("tbl_result", 32'(result), 32'(v.res));
    req = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    areset = 1'b1;
    req    = '0;
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    int waited;
    int gap;
    tbl[0] = '{4'b0001, 8'h01, 0, 1'b1};
    tbl[1] = '{4'b0001, 8'h03, 0, 1'b0};
    tbl[2] = '{4'b0001, 8'h03, 0, 1'b1};
    tbl[3] = '{4'b0100, 8'h6D, 2, 1'b0};
    tbl[4] = '{4'b1000, 8'h3F, 3, 1'b0};
    tbl[5] = '{4'b0100, 8'h9E, 2, 1'b1};
    tbl[6] = '{4'b0101, 8'hE4, 0, 1'b1};
    tbl[7] = '{4'b0101, 8'hE4, 2, 1'b0};
    tbl[8] = '{4'b0010, 8'h0C, 1, 1'b1};
    tbl[9] = '{4'b0001, 8'h02, 0, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_grant", 32'(grant_id), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_jk", 32'({j, k}), 32'd0);
    chk_en = 1'b1;
    areset = 1'b0;

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // The command must be captured at the grant edge only.
    @(negedge clk);
    req = 4'b0001;
    cmd = 8'h01;
    @(negedge clk);
    cmd = 8'h02;
    waitAck(12, waited);
    checkOutput("late_cmd_result", 32'(result), 32'd1);
    req = '0;
    applyStimulus('{4'b0001, 8'h00, 0, 1'b1});

    // All four requesters held with toggles: grants rotate, acks every 4 cycles.
    doReset();
    req = 4'b1111;
    cmd = 8'hFF;
    for (int n = 0; n < 5; n++) begin
      waitAck(12, waited);
      if (n > 0) checkOutput("rr_spacing", 32'(waited), 32'd4);
      checkOutput("rr_grant", 32'(grant_id), 32'(n % N));
      checkOutput("rr_result", 32'(result), 32'((n % 2) == 0));
    end
    req = '0;

    // Reset while SETTLE is in progress aborts the command and restarts priority at 0.
    @(negedge clk);
    req = 4'b0011;
    cmd = 8'h05;
    @(negedge clk);
    checkOutput("abort_grant", 32'(grant_id), 32'd1);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ack", 32'(ack), 32'd0);
    checkOutput("abort_jk", 32'({j, k}), 32'd0);
    checkOutput("abort_out", 32'(fsm_out), 32'd0);
    @(negedge clk);
    checkOutput("regrant_busy", 32'(busy), 32'd1);
    checkOutput("regrant_id", 32'(grant_id), 32'd0);
    waitAck(12, waited);
    checkOutput("regrant_ack", 32'(ack), 32'd1);
    checkOutput("regrant_result", 32'(result), 32'd1);
    req = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req = N'($urandom);
      if ($urandom_range(3) == 0) cmd = (2*N)'($urandom);
      areset = ($urandom_range(99) < 2);
    end
    @(negedge clk);
    areset = 1'b0;
    req    = '0;
    repeat (6) @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
